// File: rtl/tile_shader_pipe_if.sv
// Pixel/flash bundle between the playfield lookup and the tile shader.
// The shader consumes the slave view; the source drives through the master view.
interface tile_shader_pipe_if #(
   parameter int CH_W = 4
);
   logic                in_valid;
   logic [5:0]          block_x;
   logic [5:0]          block_y;
   logic [3*CH_W-1:0]   in_color;
   logic                in_mark;
   logic                frame_tick;
   logic                flash_start;
   logic                out_valid;
   logic [3*CH_W-1:0]   out_color;
   logic                flash_busy;
   logic                flash_done;

   modport master (
      output in_valid, block_x, block_y, in_color, in_mark, frame_tick, flash_start,
      input  out_valid, out_color, flash_busy, flash_done
   );

   modport slave (
      input  in_valid, block_x, block_y, in_color, in_mark, frame_tick, flash_start,
      output out_valid, out_color, flash_busy, flash_done
   );
endinterface

// File: rtl/tile_shader_pipe.sv
// Two-stage tile shader: edge/bevel/centre classification plus an optional
// frame-locked row flash sequencer, built only when TILE_SHADER_FLASH_EN is defined.
module tile_shader_pipe #(
   parameter int TILE_W      = 26,
   parameter int TILE_H      = 32,
   parameter int BEVEL       = 4,
   parameter int CH_W        = 4,
   parameter int FLASH_PAIRS = 3,
   parameter int FLASH_HOLD  = 8
) (
   input logic                clk,
   input logic                rst,
   tile_shader_pipe_if.slave  pix
);
   localparam int CW = 3 * CH_W;

   // Coordinates are compared in 7 bits so a 64-wide tile bound still fits.
   localparam logic [6:0] LP_TW    = 7'(TILE_W);
   localparam logic [6:0] LP_TH    = 7'(TILE_H);
   localparam logic [6:0] LP_XLAST = 7'(TILE_W - 1);
   localparam logic [6:0] LP_YLAST = 7'(TILE_H - 1);
   localparam logic [6:0] LP_BV    = 7'(BEVEL);
   localparam logic [6:0] LP_XC    = 7'(TILE_W - BEVEL);
   localparam logic [6:0] LP_YC    = 7'(TILE_H - BEVEL);

   localparam logic [CH_W-1:0] M_DULL  = {CH_W{1'b1}} << (CH_W - (CH_W + 1) / 2);
   localparam logic [CH_W-1:0] M_SDULL = {CH_W{1'b1}} << (CH_W - 1);

   typedef enum logic [2:0] {CL_OUT, CL_EDGE, CL_CENTRE, CL_LIGHT, CL_DARK} cls_t;

   function automatic logic [CW-1:0] dull_fn(input logic [CW-1:0] c);
      return c & {3{M_DULL}};
   endfunction

   function automatic logic [CW-1:0] sdull_fn(input logic [CW-1:0] c);
      return c & {3{M_SDULL}};
   endfunction

   logic [6:0]    w_x;
   logic [6:0]    w_y;
   cls_t          w_cls;
   logic          w_phase;
   logic          w_hot;
   logic [CW-1:0] w_color_p2;

   cls_t          r_cls_p1;
   logic [CW-1:0] r_color_p1;
   logic          r_vld_p1;
   logic          r_mark_p1;
   logic          r_phase_p1;
   logic [CW-1:0] r_color_p2;
   logic          r_vld_p2;

   assign w_x = {1'b0, pix.block_x};
   assign w_y = {1'b0, pix.block_y};

   always_comb begin
      w_cls = CL_DARK;
      if (w_x >= LP_TW || w_y >= LP_TH)
         w_cls = CL_OUT;
      else if (w_x == 7'd0 || w_y == 7'd0 || w_x == LP_XLAST || w_y == LP_YLAST)
         w_cls = CL_EDGE;
      else if (w_x >= LP_BV && w_x < LP_XC && w_y >= LP_BV && w_y < LP_YC)
         w_cls = CL_CENTRE;
      else if (w_x > w_y)
         w_cls = CL_LIGHT;
   end

`ifdef TILE_SHADER_FLASH_EN
   localparam int FW = $clog2(FLASH_HOLD + 1);
   localparam int PW = $clog2(FLASH_PAIRS + 1);
   localparam logic [FW-1:0] LP_FLAST = FW'(FLASH_HOLD - 1);
   localparam logic [PW-1:0] LP_PLAST = PW'(FLASH_PAIRS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} fl_state_t;

   fl_state_t     r_state;
   fl_state_t     w_state_nxt;
   logic [FW-1:0] r_fcnt;
   logic [FW-1:0] w_fcnt_nxt;
   logic [PW-1:0] r_pcnt;
   logic [PW-1:0] w_pcnt_nxt;
   logic          r_done;
   logic          w_done_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_fcnt  <= '0;
         r_pcnt  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
         r_pcnt  <= w_pcnt_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // A start request only counts from IDLE; any tick arriving with it is dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      w_pcnt_nxt  = r_pcnt;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (pix.flash_start) begin
               w_state_nxt = ST_ON;
               w_fcnt_nxt  = '0;
               w_pcnt_nxt  = '0;
            end
         end
         ST_ON: begin
            if (pix.frame_tick) begin
               if (r_fcnt == LP_FLAST) begin
                  w_state_nxt = ST_OFF;
                  w_fcnt_nxt  = '0;
               end else begin
                  w_fcnt_nxt = r_fcnt + 1'b1;
               end
            end
         end
         ST_OFF: begin
            if (pix.frame_tick) begin
               if (r_fcnt == LP_FLAST) begin
                  w_fcnt_nxt = '0;
                  if (r_pcnt == LP_PLAST) begin
                     w_state_nxt = ST_IDLE;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = ST_ON;
                     w_pcnt_nxt  = r_pcnt + 1'b1;
                  end
               end else begin
                  w_fcnt_nxt = r_fcnt + 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_phase        = (r_state == ST_ON);
   assign w_hot          = r_phase_p1 & r_mark_p1;
   assign pix.flash_busy = (r_state != ST_IDLE);
   assign pix.flash_done = r_done;
`else
   logic w_unused;

   assign w_unused       = ^{pix.in_mark, pix.flash_start, pix.frame_tick, r_mark_p1, r_phase_p1};
   assign w_phase        = 1'b0;
   assign w_hot          = 1'b0;
   assign pix.flash_busy = 1'b0;
   assign pix.flash_done = 1'b0;
`endif

   // Stage 1: class, colour, mark and the flash phase seen when the pixel arrived.
   always_ff @(posedge clk) begin
      if (rst) r_vld_p1 <= 1'b0;
      else     r_vld_p1 <= pix.in_valid;
   end

   always_ff @(posedge clk) begin
      r_cls_p1   <= w_cls;
      r_color_p1 <= pix.in_color;
      r_mark_p1  <= pix.in_mark;
      r_phase_p1 <= w_phase;
   end

   always_comb begin
      w_color_p2 = '0;
      case (r_cls_p1)
         CL_OUT:    w_color_p2 = '0;
         CL_EDGE:   w_color_p2 = '1;
         CL_CENTRE: w_color_p2 = dull_fn(r_color_p1);
         CL_LIGHT:  w_color_p2 = r_color_p1;
         CL_DARK:   w_color_p2 = sdull_fn(r_color_p1);
         default:   w_color_p2 = '0;
      endcase
      if (w_hot && r_cls_p1 != CL_OUT)
         w_color_p2 = '1;
   end

   // Stage 2: shaded colour and output qualifier.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p2   <= 1'b0;
         r_color_p2 <= '0;
      end else begin
         r_vld_p2   <= r_vld_p1;
         r_color_p2 <= w_color_p2;
      end
   end

   assign pix.out_valid = r_vld_p2;
   assign pix.out_color = r_color_p2;
endmodule

// File: tb/tb_tile_shader_pipe.sv
// Directed bench for tile_shader_pipe with a frame-count model of the flash
// sequence; follows TILE_SHADER_FLASH_EN to pick the expected behaviour.
module tb_tile_shader_pipe;
   localparam int TW    = 26;
   localparam int TH    = 32;
   localparam int BV    = 4;
   localparam int HOLD  = 2;
   localparam int PAIRS = 2;
`ifdef TILE_SHADER_FLASH_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   passes = 0;

   tile_shader_pipe_if #(.CH_W(4)) bus();

   tile_shader_pipe #(
      .TILE_W(TW), .TILE_H(TH), .BEVEL(BV), .CH_W(4),
      .FLASH_PAIRS(PAIRS), .FLASH_HOLD(HOLD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pix(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      else
         passes++;
   endtask

   // Shading rules written straight from the classification table.
   function automatic logic [11:0] shade(input int x, input int y, input logic [11:0] c, input bit hot);
      if (x >= TW || y >= TH) return 12'h000;
      if (hot) return 12'hFFF;
      if (x == 0 || y == 0 || x == TW-1 || y == TH-1) return 12'hFFF;
      if (x >= BV && x < TW-BV && y >= BV && y < TH-BV) return c & 12'hCCC;
      if (x > y) return c;
      return c & 12'h888;
   endfunction

   // Model: the flash is a count of ticks since start; ON while (ticks/HOLD) is even.
   bit          m_busy = 0;
   int          m_ticks = 0;
   bit          e_vld = 0, e_busy = 0, e_done = 0, p1_vld = 0;
   logic [11:0] e_col = '0, p1_col = '0;

   initial begin
      bit hot;
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("out_valid", 32'(bus.out_valid), 32'(e_vld));
         if (e_vld) chk("out_color", 32'(bus.out_color), 32'(e_col));
         chk("flash_busy", 32'(bus.flash_busy), 32'(e_busy));
         chk("flash_done", 32'(bus.flash_done), 32'(e_done));
         if (rst) begin
            e_vld = 0; e_col = '0; p1_vld = 0;
            m_busy = 0; m_ticks = 0; e_busy = 0; e_done = 0;
         end else begin
            hot    = FL && m_busy && ((m_ticks / HOLD) % 2 == 0) && bus.in_mark;
            e_vld  = p1_vld;
            e_col  = p1_col;
            p1_vld = bus.in_valid;
            p1_col = shade(int'(bus.block_x), int'(bus.block_y), bus.in_color, hot);
            e_done = 0;
            if (FL) begin
               if (!m_busy) begin
                  if (bus.flash_start) begin
                     m_busy  = 1;
                     m_ticks = 0;
                  end
               end else if (bus.frame_tick) begin
                  m_ticks++;
                  if (m_ticks == 2 * PAIRS * HOLD) begin
                     m_busy = 0;
                     e_done = 1;
                  end
               end
            end
            e_busy = m_busy;
         end
      end
   end

   task automatic cyc(input bit v, input int x, input int y, input logic [11:0] c,
                      input bit m, input bit tk, input bit st);
      bus.in_valid    = v;
      bus.block_x     = 6'(x);
      bus.block_y     = 6'(y);
      bus.in_color    = c;
      bus.in_mark     = m;
      bus.frame_tick  = tk;
      bus.flash_start = st;
      @(posedge clk);
      #1;
   endtask

   int          xa[5]  = '{0, 10, 5, 2, 30};
   int          ya[5]  = '{5, 10, 2, 5, 0};
   logic [11:0] ea[5]  = '{12'hFFF, 12'hC84, 12'hFA5, 12'h880, 12'h000};
   int          xb[3]  = '{25, 4, 3};
   int          yb[3]  = '{31, 4, 4};
   logic [11:0] eb[3]  = '{12'hFFF, 12'hCCC, 12'h888};
   bit          vp[5]  = '{1, 0, 1, 1, 0};
   bit          win[8] = '{1, 1, 0, 0, 1, 1, 0, 0};

   initial begin
      bus.in_valid = 0; bus.block_x = '0; bus.block_y = '0; bus.in_color = '0;
      bus.in_mark = 0; bus.frame_tick = 0; bus.flash_start = 0;
      rst = 1;
      cyc(1, 10, 10, 12'hFA5, 1, 1, 1);
      cyc(1, 10, 10, 12'hFA5, 1, 1, 1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_color", 32'(bus.out_color), 32'd0);
      chk("rst_flash_busy", 32'(bus.flash_busy), 32'd0);
      chk("rst_flash_done", 32'(bus.flash_done), 32'd0);
      rst = 0;

      for (int i = 0; i <= 5; i++) begin
         if (i < 5) cyc(1, xa[i], ya[i], 12'hFA5, 0, 0, 0);
         else       cyc(0, 0, 0, 12'h000, 0, 0, 0);
         if (i >= 1) begin
            chk("stream_valid", 32'(bus.out_valid), 32'd1);
            chk("stream_color", 32'(bus.out_color), 32'(ea[i-1]));
         end
      end

      for (int i = 0; i <= 3; i++) begin
         if (i < 3) cyc(1, xb[i], yb[i], 12'hFFF, 0, 0, 0);
         else       cyc(0, 0, 0, 12'h000, 0, 0, 0);
         if (i >= 1) chk("boundary_color", 32'(bus.out_color), 32'(eb[i-1]));
      end

      for (int i = 0; i <= 5; i++) begin
         if (i < 5) cyc(vp[i], 12, 12, 12'h5A3, 0, 0, 0);
         else       cyc(0, 0, 0, 12'h000, 0, 0, 0);
         if (i >= 1) chk("valid_pattern", 32'(bus.out_valid), 32'(vp[i-1]));
      end

      cyc(1, 7, 3, 12'h123, 0, 0, 0);
      cyc(1, 3, 7, 12'h456, 0, 0, 0);
      rst = 1;
      cyc(1, 8, 8, 12'h789, 0, 0, 0);
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_out_color", 32'(bus.out_color), 32'd0);
      rst = 0;
      cyc(0, 0, 0, 12'h000, 0, 0, 0);

      // Basic flash sequence with marked centre pixels streaming throughout.
      cyc(1, 10, 10, 12'hFA5, 1, 0, 1);
      chk("start_busy", 32'(bus.flash_busy), 32'(FL));
      for (int t = 0; t < 8; t++) begin
         for (int s = 0; s < 4; s++) begin
            cyc(1, 10, 10, 12'hFA5, 1, s == 3, 0);
            if (s == 2) chk("flash_window", 32'(bus.out_color),
                            32'((FL && win[t]) ? 12'hFFF : 12'hC84));
         end
      end
      chk("end_done", 32'(bus.flash_done), 32'(FL));
      chk("end_busy", 32'(bus.flash_busy), 32'd0);
      cyc(1, 10, 10, 12'hFA5, 1, 0, 0);
      chk("done_pulse_len", 32'(bus.flash_done), 32'd0);

      // Re-issued starts while busy, including one together with a tick.
      cyc(1, 2, 20, 12'h7E3, 1, 0, 1);
      for (int t = 0; t < 8; t++) begin
         for (int s = 0; s < 4; s++) begin
            cyc(1, 2 + s, 20, 12'h7E3, 1, s == 3, (t == 3 && s == 0) || (t == 5 && s == 3));
            if (t == 6 && s == 3) chk("restart_no_early_done", 32'(bus.flash_done), 32'd0);
         end
      end
      chk("restart_done", 32'(bus.flash_done), 32'(FL));
      cyc(0, 0, 0, 12'h000, 0, 0, 0);

      // Start together with a tick in IDLE: that tick is not counted.
      cyc(1, 20, 1, 12'hBBB, 1, 1, 1);
      for (int t = 0; t < 8; t++) begin
         for (int s = 0; s < 4; s++) begin
            cyc(1, 20, 1 + s, 12'hBBB, 1, s == 3, 0);
            if (t == 6 && s == 3) begin
               chk("tickstart_no_done", 32'(bus.flash_done), 32'd0);
               chk("tickstart_busy", 32'(bus.flash_busy), 32'(FL));
            end
         end
      end
      chk("tickstart_done", 32'(bus.flash_done), 32'(FL));

      // Reset part way through aborts without a done pulse.
      cyc(1, 9, 9, 12'h3C6, 1, 0, 1);
      for (int t = 0; t < 3; t++)
         for (int s = 0; s < 4; s++) cyc(1, 9, 9, 12'h3C6, 1, s == 3, 0);
      rst = 1;
      cyc(1, 9, 9, 12'h3C6, 1, 0, 0);
      chk("abort_busy", 32'(bus.flash_busy), 32'd0);
      chk("abort_done", 32'(bus.flash_done), 32'd0);
      rst = 0;
      for (int t = 0; t < 6; t++)
         for (int s = 0; s < 4; s++) cyc(1, 9, 9, 12'h3C6, 1, s == 3, 0);

      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 12'h000, 0, 0, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
